// File: rtl/timer_pkg.sv
// Shared types and helpers for the stopwatch/timer front end.
//   timer_state_t : FSM encoding (idle, running, paused)
//   calc_div      : clock cycles per tick for a given clock and tick rate
package timer_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2
  } timer_state_t;

  // A zero tick rate yields 0 so the caller's DIV >= 2 check rejects it.
  function automatic int unsigned calc_div(input int unsigned clk_freq_hz,
                                           input int unsigned tick_hz);
    return (tick_hz == 0) ? 0 : clk_freq_hz / tick_hz;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Synchronises and debounces one raw, asynchronous, active-high button.
//   clk_i     : clock
//   rst_ni    : asynchronous active-low reset
//   btn_raw_i : raw button level
//   press_o   : 1-cycle registered pulse on each accepted 0->1 level change
//   level_o   : debounced button level
// A new level is accepted after the synchronised input has differed from the
// current level for DebounceCycles consecutive cycles; any return to the
// current level restarts the count.
module button_debounce #(
  parameter int unsigned DebounceCycles = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_raw_i,
  output logic press_o,
  output logic level_o
);

  if (DebounceCycles < 1) begin : gen_cycles_check
    $error("button_debounce: DebounceCycles must be >= 1");
  end

  // Counter only needs to reach DebounceCycles-1.
  localparam int unsigned CntW = (DebounceCycles < 2) ? 1 : $clog2(DebounceCycles);
  localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles - 1);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic            press_q, press_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      // Stable long enough: accept the new level; only rising edges are presses.
      cnt_d   = '0;
      level_d = sync2_q;
      press_d = sync2_q;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press_o = press_q;
  assign level_o = level_q;

endmodule

// File: rtl/timer_control.sv
// Stopwatch/timer front end feeding the mod-N digit-counter chain.
//   clk_i       : clock
//   rst_ni      : asynchronous active-low reset
//   btn_run_i   : raw run/pause button (async, active-high)
//   btn_clear_i : raw clear button (async, active-high)
//   tick_o      : 1-cycle increment pulse for the first digit counter
//   clear_o     : 1-cycle synchronous clear for the digit counters (high in reset)
//   running_o   : FSM is in RUN (registered)
//   paused_o    : FSM is in PAUSE (registered)
module timer_control
  import timer_pkg::*;
#(
  parameter int unsigned ClkFreqHz      = 100_000_000,
  parameter int unsigned TickHz         = 100,
  parameter int unsigned DebounceCycles = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_run_i,
  input  logic btn_clear_i,
  output logic tick_o,
  output logic clear_o,
  output logic running_o,
  output logic paused_o
);

  localparam int unsigned Div = calc_div(ClkFreqHz, TickHz);

  if (Div < 2) begin : gen_div_check
    $error("timer_control: ClkFreqHz/TickHz must be >= 2");
  end

  localparam int unsigned PresW = (Div < 2) ? 1 : $clog2(Div);
  localparam logic [PresW-1:0] PresMax = PresW'(Div - 1);

  logic run_press, run_level;
  logic clr_press, clr_level;
  logic unused_levels;

  button_debounce #(
    .DebounceCycles(DebounceCycles)
  ) u_run_db (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .btn_raw_i(btn_run_i),
    .press_o  (run_press),
    .level_o  (run_level)
  );

  button_debounce #(
    .DebounceCycles(DebounceCycles)
  ) u_clr_db (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .btn_raw_i(btn_clear_i),
    .press_o  (clr_press),
    .level_o  (clr_level)
  );

  assign unused_levels = run_level ^ clr_level;

  timer_state_t     state_q;
  logic [PresW-1:0] pres_q;
  logic             clear_q, running_q, paused_q;

  // Prescaler follows the current state: counts in RUN, holds in PAUSE so a
  // resume finishes the partial period, and is zeroed in IDLE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      pres_q    <= '0;
      clear_q   <= 1'b1;
      running_q <= 1'b0;
      paused_q  <= 1'b0;
    end else begin
      clear_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          pres_q <= '0;
          // Clear wins over run when both arrive together.
          if (clr_press) begin
            clear_q <= 1'b1;
          end else if (run_press) begin
            state_q   <= StRun;
            running_q <= 1'b1;
          end
        end
        StRun: begin
          pres_q <= (pres_q == PresMax) ? '0 : pres_q + PresW'(1);
          // Clear is ignored while running.
          if (run_press) begin
            state_q   <= StPause;
            running_q <= 1'b0;
            paused_q  <= 1'b1;
          end
        end
        StPause: begin
          if (clr_press) begin
            state_q  <= StIdle;
            clear_q  <= 1'b1;
            paused_q <= 1'b0;
          end else if (run_press) begin
            state_q   <= StRun;
            running_q <= 1'b1;
            paused_q  <= 1'b0;
          end
        end
        default: begin
          state_q   <= StIdle;
          pres_q    <= '0;
          running_q <= 1'b0;
          paused_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tick_o    = (state_q == StRun) && (pres_q == PresMax);
  assign clear_o   = clear_q;
  assign running_o = running_q;
  assign paused_o  = paused_q;

endmodule

// File: tb/tb_timer_control.sv
// Directed bench for timer_control with DIV=10 and a 4-cycle debounce.
module tb_timer_control;

  logic clk = 1'b0;
  logic rst_n, btn_run, btn_clear;
  logic tick, clear, running, paused;

  always #5 clk = ~clk;

  timer_control #(
    .ClkFreqHz     (20),
    .TickHz        (2),
    .DebounceCycles(4)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .btn_run_i  (btn_run),
    .btn_clear_i(btn_clear),
    .tick_o     (tick),
    .clear_o    (clear),
    .running_o  (running),
    .paused_o   (paused)
  );

  int checks = 0;
  int errors = 0;

  // Downstream MOD 10 digit counter driven by tick/clear.
  int digit;
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n)     digit <= 0;
    else if (clear) digit <= 0;
    else if (tick)  digit <= (digit + 1) % 10;
  end

  typedef struct {
    logic run;
    logic clr;
    logic e_tick;
    logic e_clear;
    logic e_running;
    logic e_paused;
  } vec_t;

  vec_t vecs[20];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic et, input logic ec,
                         input logic er, input logic ep);
    chk({name, "_tick"}, 32'(tick), 32'(et));
    chk({name, "_clear"}, 32'(clear), 32'(ec));
    chk({name, "_running"}, 32'(running), 32'(er));
    chk({name, "_paused"}, 32'(paused), 32'(ep));
  endtask

  task automatic wait_tick(input int max_cycles, output bit found);
    found = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      step();
      if (tick) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit found;
    int quiet, bad, ticks, clear_seen;

    // Run held 10 cycles: press visible after edge 6, RUN after edge 7,
    // first tick after edge 16 (vector k is checked after edge k+1).
    for (int i = 0; i < 20; i++) begin
      vecs[i].run       = (i < 10);
      vecs[i].clr       = 1'b0;
      vecs[i].e_tick    = (i == 15);
      vecs[i].e_clear   = 1'b0;
      vecs[i].e_running = (i >= 6);
      vecs[i].e_paused  = 1'b0;
    end

    rst_n = 1'b0; btn_run = 1'b0; btn_clear = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_out("reset", 1'b0, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("clear_held_after_release", 32'(clear), 32'd1);
    step();
    chk_out("first_edge", 1'b0, 1'b0, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      btn_run   = vecs[i].run;
      btn_clear = vecs[i].clr;
      step();
      chk_out($sformatf("vec%0d", i), vecs[i].e_tick, vecs[i].e_clear,
              vecs[i].e_running, vecs[i].e_paused);
    end

    // Ticks after edges 26, 36, 46, 56 with nothing in between.
    for (int p = 0; p < 4; p++) begin
      quiet = 0;
      repeat ((p == 0) ? 5 : 9) begin
        step();
        quiet += int'(tick);
      end
      step();
      chk($sformatf("tick_period%0d", p), 32'(tick), 32'd1);
      chk($sformatf("tick_gap%0d", p), 32'(quiet), 32'd0);
    end
    step();
    chk("digit_after_5_ticks", 32'(digit), 32'd5);

    // 3-cycle glitch on run while running: ignored.
    btn_run = 1'b1;
    repeat (3) step();
    btn_run = 1'b0;
    bad = 0;
    repeat (8) begin
      step();
      bad += int'(!running || paused);
    end
    chk("glitch_ignored", 32'(bad), 32'd0);

    // Align so the run press lands while the prescaler is 6.
    wait_tick(15, found);
    chk("tick_before_pause", 32'(found), 32'd1);
    step();
    btn_run = 1'b1;
    repeat (4) step();
    btn_run = 1'b0;
    step();
    step();
    chk_out("press_visible", 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    chk_out("paused", 1'b0, 1'b0, 1'b0, 1'b1);
    ticks = 0; bad = 0;
    repeat (50) begin
      step();
      ticks += int'(tick);
      bad += int'(!paused || running);
    end
    chk("pause_no_ticks", 32'(ticks), 32'd0);
    chk("pause_held", 32'(bad), 32'd0);

    // Resume: prescaler held at 7 -> tick on the third RUN cycle.
    btn_run = 1'b1;
    repeat (4) step();
    btn_run = 1'b0;
    repeat (3) step();
    chk_out("resume_cycle1", 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    chk("resume_cycle2_tick", 32'(tick), 32'd0);
    step();
    chk("resume_cycle3_tick", 32'(tick), 32'd1);

    // Pause again, then both buttons together: clear wins.
    btn_run = 1'b1;
    repeat (4) step();
    btn_run = 1'b0;
    repeat (3) step();
    chk("pause2", 32'(paused), 32'd1);
    repeat (8) step();
    chk("digit_before_clear", 32'(digit), 32'd8);
    btn_run = 1'b1; btn_clear = 1'b1;
    repeat (4) step();
    btn_run = 1'b0; btn_clear = 1'b0;
    step();
    step();
    chk_out("both_pending", 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    chk_out("both_clear_pulse", 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    chk_out("both_clear_done", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("digit_cleared", 32'(digit), 32'd0);
    repeat (10) step();

    // Start from IDLE (prescaler zeroed), then clear while running is ignored.
    btn_run = 1'b1;
    ticks = 0; clear_seen = 0;
    for (int i = 1; i <= 16; i++) begin
      step();
      if (i == 4)  btn_run = 1'b0;
      if (i == 7)  btn_clear = 1'b1;
      if (i == 11) btn_clear = 1'b0;
      clear_seen += int'(clear);
      if (i < 16) ticks += int'(tick);
    end
    chk("idle_start_first_tick", 32'(tick), 32'd1);
    chk("idle_start_no_early_tick", 32'(ticks), 32'd0);
    chk("run_clear_ignored", 32'(clear_seen), 32'd0);
    chk("run_clear_still_running", 32'(running), 32'd1);

    // Asynchronous reset between edges while tick is high.
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("async_reset", 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    chk_out("after_reset", 1'b0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
